wb_dma_master: RTL and testbench
================================

# wb_dma_master

Wishbone bus master that copies a block of 32-bit words from a source address range to a destination address range with single read/write cycles. It is intended for an unused master port of the system interconnect (port m2). It frees the CPU from word-by-word copies between data BRAM, instruction BRAM and peripherals. A local control interface starts each transfer, and the block reports completion, progress and error.

## Interface
- `TIMEOUT`, 255: cycles `wb_stb_o` may stay high without `wb_ack_i` before the transfer aborts; range 1..65535.
- `wb_clk_i` in 1: system clock.
- `wb_rstn_i` in 1: reset; asynchronous, active-low.
- `start_i` in 1: one-cycle request to start a transfer; ignored while `busy_o`=1.
- `src_addr_i` in 32: source byte address, sampled on accepted start; bits [1:0] forced to 00.
- `dst_addr_i` in 32: destination byte address, sampled on accepted start; bits [1:0] forced to 00.
- `len_i` in 16: word count, sampled on accepted start; 0 is legal.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle pulse when a transfer ends, whether it completes or aborts.
- `err_o` out 1: one-cycle pulse coincident with `done_o` on abort.
- `count_o` out 16: number of words fully written in the current or last transfer.
- `wb_adr_o` out 32: Wishbone address.
- `wb_dat_o` out 32: Wishbone write data.
- `wb_dat_i` in 32: Wishbone read data.
- `wb_sel_o` out 4: byte selects; always 4'b1111 during a cycle, 0 otherwise.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_cyc_o` out 1: Wishbone bus cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.

## Operation
- States: IDLE, READ, RGAP, WRITE, WGAP, FIN.
- IDLE -> READ on `start_i` with `len_i`≠0. IDLE -> FIN on `start_i` with `len_i`=0; no bus traffic occurs.
- On an accepted start:
  - src, dst and len are latched.
  - `count_o` clears to 0.
  - The word index i is set to 0.
- READ:
  - Drives `wb_cyc_o`=`wb_stb_o`=1, `wb_we_o`=0, `wb_adr_o`=src+4·i.
  - On `wb_ack_i`, `wb_dat_i` is captured into the data buffer and the state moves to RGAP.
- RGAP: one cycle with `wb_cyc_o`=`wb_stb_o`=0, then -> WRITE.
- WRITE:
  - Drives `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=1, `wb_adr_o`=dst+4·i, `wb_dat_o`=buffer.
  - On `wb_ack_i`, `count_o` increments and the state moves to WGAP.
- WGAP: one cycle with the bus idle. If `count_o`=len -> FIN; otherwise i increments and the state returns to READ.
- FIN: `done_o`=1 for one cycle, then -> IDLE.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Abort: `wb_err_i`=1 in READ or WRITE, or the wait counter reaching `TIMEOUT`, sends the state directly to FIN.
  - `err_o`=1 in FIN.
  - `wb_cyc_o` and `wb_stb_o` drop on the next edge.
  - `count_o` holds the number of completed words.
- The wait counter clears on entry to READ or WRITE and increments each cycle `wb_stb_o`=1 with no ack. If ack and timeout coincide, ack wins.
- If `wb_ack_i` and `wb_err_i` arrive together, err wins.
- `busy_o`=1 in every state except IDLE.

## Timing
- Reset values: all outputs are 0, state is IDLE, and `wb_adr_o`, `wb_dat_o` and `count_o` are 0.
- Reset asserted mid-transfer clears `wb_cyc_o`/`wb_stb_o` asynchronously. No done or err pulse is issued.
- `wb_ack_i`, `wb_err_i` and `wb_dat_i` are sampled on the rising edge of `wb_clk_i`. All outputs are registered.
- Start accepted at edge N: READ outputs are valid in cycle N+1.
- With a zero-wait slave (ack in the first cycle of stb), each word costs 4 cycles: READ, RGAP, WRITE, WGAP.
- Each slave wait state adds 1 cycle per access.
- Total for len=L with zero wait: 4L cycles plus 1 FIN cycle. `busy_o` falls the cycle after `done_o`.
- len=0: FIN in cycle N+1.
- `start_i` asserted in the FIN cycle is ignored. A start asserted in the cycle after FIN is accepted.

## Structure
- Shared package holds:
  - the state encoding (6 states, 3 bits);
  - `ZeroWord` (32'h0);
  - `SEL_ALL` (4'b1111);
  - the word stride constant (4).
- One sub-module, `wb_ack_timer`: the `TIMEOUT` wait counter. It takes clear, count-enable and ack, and outputs an expired flag.
- Everything else lives in a single always-block FSM plus a datapath.

## Test plan
- len=3, src=0x0000_0100, dst=0x2000_0010, zero-wait slave:
  - reads at 0x100, 0x104, 0x108;
  - writes at 0x2000_0010, 0x2000_0014, 0x2000_0018 with the read data;
  - `done_o` in cycle 13 after start, `count_o`=3, `err_o`=0.
- len=0 -> `done_o` in cycle 1 after start, `wb_cyc_o` never asserted, `count_o`=0.
- len=2 with a slave inserting 3 wait states per access -> `done_o` in cycle 21 after start.
- Start pulsed while busy -> ignored; the transfer and latched addresses are unchanged.
- len=4, `wb_err_i` on the second read -> `err_o`=`done_o`=1, `count_o`=1, no further bus cycles.
- `TIMEOUT`=8 with a slave that never acks -> abort after 8 stb cycles with `err_o`=1.
- Separate run: `wb_rstn_i` pulled low mid-WRITE -> `wb_cyc_o` falls immediately and all outputs return to 0.
- Separate run: src=0xFFFF_FFFC, len=2 -> second read at 0x0000_0000.

Source files
------------

// File: rtl/wb_dma_master_pkg.sv
// wb_dma_master_pkg: state encoding and bus constants shared by the DMA master and its timer.
package wb_dma_master_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_RGAP  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WGAP  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [3:0] SEL_ALL = 4'b1111;
  localparam logic [31:0] WORD_STRIDE = 32'd4;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + 32'(idx) * WORD_STRIDE;
  endfunction
endpackage

// File: rtl/wb_dma_master_ack_timer.sv
// wb_ack_timer: counts strobe cycles without ack; expired fires on the cycle the count would reach TIMEOUT.
module wb_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ack,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !ack) cnt <= cnt + 16'd1;
  // an ack in the final wait cycle still completes the access
  assign expired = en && !ack && (cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/wb_dma_master.sv
// wb_dma_master: Wishbone block copier, one read then one write per word, with error/timeout abort.
module wb_dma_master
  import wb_dma_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] count_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  logic [2:0] state;
  logic [31:0] src, dst;
  logic [15:0] len, idx;
  logic expired;
  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(wb_clk_i), .rst_n(wb_rstn_i), .clr(!wb_stb_o), .en(wb_stb_o), .ack(wb_ack_i), .expired(expired)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= ST_IDLE;
      src <= ZeroWord;
      dst <= ZeroWord;
      len <= '0;
      idx <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      count_o <= '0;
      wb_adr_o <= ZeroWord;
      wb_dat_o <= ZeroWord;
      wb_sel_o <= '0;
      wb_we_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        ST_IDLE: if (start_i) begin
          src <= src_addr_i & ~32'h3;
          dst <= dst_addr_i & ~32'h3;
          len <= len_i;
          idx <= '0;
          count_o <= '0;
          busy_o <= 1'b1;
          if (len_i == 16'd0) begin
            state <= ST_FIN;
            done_o <= 1'b1;
          end else begin
            state <= ST_READ;
            wb_adr_o <= src_addr_i & ~32'h3;
            {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} <= {1'b1, 1'b1, 1'b0, SEL_ALL};
          end
        end
        ST_READ, ST_WRITE: begin
          // error takes priority over a simultaneous ack
          if (wb_err_i || expired) begin
            state <= ST_FIN;
            done_o <= 1'b1;
            err_o <= 1'b1;
            {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} <= '0;
          end else if (wb_ack_i) begin
            state <= (state == ST_READ) ? ST_RGAP : ST_WGAP;
            if (state == ST_READ) wb_dat_o <= wb_dat_i;
            else count_o <= count_o + 16'd1;
            {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} <= '0;
          end
        end
        ST_RGAP: begin
          state <= ST_WRITE;
          wb_adr_o <= word_addr(dst, idx);
          {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} <= {1'b1, 1'b1, 1'b1, SEL_ALL};
        end
        ST_WGAP: if (count_o == len) begin
          state <= ST_FIN;
          done_o <= 1'b1;
        end else begin
          state <= ST_READ;
          idx <= idx + 16'd1;
          wb_adr_o <= word_addr(src, idx + 16'd1);
          {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} <= {1'b1, 1'b1, 1'b0, SEL_ALL};
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_dma_master.sv
// tb_wb_dma_master: scoreboarded bench with a configurable Wishbone slave (waits, no-ack, error address).
module tb_wb_dma_master;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
  logic busy, done, err, we, cyc, stb, ack, werr;
  logic [15:0] count;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0] sel;
  int waits = 0;
  bit no_ack = 0, err_en = 0;
  logic [31:0] err_adr = '0;
  int wcnt = 0, stb_cnt = 0, cyc_cnt = 0;
  int n_chk = 0, n_err = 0;
  txn_t sb[$];

  wb_dma_master #(.TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
    .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_sel_o(sel), .wb_we_o(we),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_ack_i(ack), .wb_err_i(werr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign dat_i = mem(adr);
  assign ack = cyc && stb && !no_ack && (wcnt == waits);
  assign werr = cyc && stb && !we && err_en && (adr == err_adr);

  always @(posedge clk) begin
    wcnt <= (!cyc || !stb || ack) ? 0 : wcnt + 1;
    if (stb) stb_cnt <= stb_cnt + 1;
    if (cyc) cyc_cnt <= cyc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rstn && cyc && stb && ack && !werr) begin
    if (sb.size() == 0) chk("unexpected_txn", 32'd1, 32'd0);
    else begin
      txn_t e;
      e = sb.pop_front();
      chk("txn_we", {31'd0, we}, {31'd0, e.we});
      chk("txn_adr", adr, e.adr);
      chk("txn_sel", {28'd0, sel}, 32'hF);
      if (e.we) chk("txn_wdat", dat_o, e.dat);
    end
  end

  task automatic push_words(input logic [31:0] s, input logic [31:0] d, input int n);
    s &= ~32'h3;
    d &= ~32'h3;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{1'b0, s + 32'(4 * k), 32'h0});
      sb.push_back('{1'b1, d + 32'(4 * k), mem(s + 32'(4 * k))});
    end
  endtask

  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input bit poke,
                      input int exp_dc, input logic exp_err, input logic [15:0] exp_cnt, input string tag);
    int dc;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src = '0; dst = '0; len = '0;
    dc = 1;
    while (!done && dc < 300) begin
      if (poke && dc == 5) begin
        start = 1'b1; src = 32'hDEAD_0000; dst = 32'hBEEF_0000; len = 16'd9;
      end else start = 1'b0;
      @(negedge clk);
      dc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, dc, exp_dc);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_count"}, {16'd0, count}, {16'd0, exp_cnt});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cyc"}, {31'd0, cyc}, 0);
    chk({tag, "_stb"}, {31'd0, stb}, 0);
    chk({tag, "_we"}, {31'd0, we}, 0);
    chk({tag, "_sel"}, {28'd0, sel}, 0);
    chk({tag, "_adr"}, adr, 0);
    chk({tag, "_dat"}, dat_o, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_count"}, {16'd0, count}, 0);
  endtask

  initial begin
    int s0, c0, guard;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    push_words(32'h0000_0100, 32'h2000_0010, 3);
    xfer(32'h0000_0100, 32'h2000_0010, 16'd3, 0, 13, 1'b0, 16'd3, "len3");
    c0 = cyc_cnt;
    xfer(32'h0000_0500, 32'h0000_0600, 16'd0, 0, 1, 1'b0, 16'd0, "len0");
    chk("len0_no_cyc", cyc_cnt - c0, 0);
    waits = 3;
    push_words(32'h0000_0303, 32'h0000_0A01, 2);
    xfer(32'h0000_0303, 32'h0000_0A01, 16'd2, 0, 21, 1'b0, 16'd2, "wait3");
    waits = 0;
    push_words(32'h0000_0800, 32'h0000_0C00, 3);
    xfer(32'h0000_0800, 32'h0000_0C00, 16'd3, 1, 13, 1'b0, 16'd3, "poke");
    err_en = 1; err_adr = 32'h0000_1004;
    push_words(32'h0000_1000, 32'h0000_2000, 1);
    xfer(32'h0000_1000, 32'h0000_2000, 16'd4, 0, 6, 1'b1, 16'd1, "rderr");
    s0 = stb_cnt;
    repeat (5) @(negedge clk);
    chk("rderr_quiet", stb_cnt - s0, 0);
    err_en = 0; no_ack = 1;
    s0 = stb_cnt;
    xfer(32'h0000_3000, 32'h0000_4000, 16'd2, 0, 9, 1'b1, 16'd0, "tmo");
    chk("tmo_stb_cycles", stb_cnt - s0, 9 - 1);
    no_ack = 0; waits = 3;
    push_words(32'h0000_0500, 32'h0000_0600, 2);
    @(negedge clk);
    src = 32'h0000_0500; dst = 32'h0000_0600; len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(cyc && we) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reached_write", {31'd0, cyc && we}, 32'd1);
    #1 rstn = 1'b0;
    #1 chk_idle_outputs("rst_mid");
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_done", {31'd0, done || err}, 0);
    end
    rstn = 1'b1;
    waits = 0;
    push_words(32'hFFFF_FFFC, 32'h0000_0040, 2);
    xfer(32'hFFFF_FFFC, 32'h0000_0040, 16'd2, 0, 9, 1'b0, 16'd2, "wrap");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
